// File: rtl/mdio_apb_bridge_if.sv
// Bus bundles for the MDIO-to-APB bridge: the level request from the MDIO backend
// and the APB3 master port towards the chip register fabric.

interface mdio_req_if #(
    parameter int ADDR_W = 21
);
    logic              psel;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [15:0]       pwdata;
    logic              pready;
    logic [15:0]       prdata;

    modport master (output psel, pwrite, paddr, pwdata, input pready, prdata);
    modport slave  (input psel, pwrite, paddr, pwdata, output pready, prdata);
endinterface

interface mdio_apb_bridge_if #(
    parameter int ADDR_W = 21
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [15:0]       pwdata;
    logic [15:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/mdio_apb_bridge.sv
// Turns the MDIO backend's level request into one APB3 transfer, with an address
// limit, an ACCESS-phase timeout and error bookkeeping so a dead slave never stalls MDIO.

module mdio_apb_bridge #(
    parameter int                ADDR_W      = 21,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = '1,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [15:0]       ERR_RDATA   = 16'hFFFF
) (
    input  logic              clk_200m,
    input  logic              rstn_200m,
    mdio_req_if.slave         req,
    mdio_apb_bridge_if.master m,
    input  logic              err_clr,
    output logic [7:0]        err_cnt,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] last_err_addr
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_WAITLOW
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic [ADDR_W-1:0] last_err_q, last_err_d;
    logic              done_err;
    logic              over_limit;
    logic              apb_sel;

    // Widened compare keeps the check meaningful even when the limit is all ones.
    assign over_limit = ({1'b0, req.paddr} > {1'b0, ADDR_LIMIT});

    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            tmo_q        <= '0;
            rdata_q      <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            last_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            tmo_q        <= tmo_d;
            rdata_q      <= rdata_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            last_err_q   <= last_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        tmo_d        = tmo_q;
        rdata_d      = rdata_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        last_err_d   = last_err_q;
        done_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req.psel) begin
                    addr_d  = req.paddr;
                    wdata_d = req.pwdata;
                    write_d = req.pwrite;
                    if (over_limit) begin
                        done_err = 1'b1;
                        if (!req.pwrite) rdata_d = ERR_RDATA;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                tmo_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m.pready) begin
                    done_err = m.pslverr;
                    if (!write_q) rdata_d = m.pslverr ? ERR_RDATA : m.prdata;
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    done_err = 1'b1;
                    if (!write_q) rdata_d = ERR_RDATA;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                tmo_d   = '0;
                state_d = ST_WAITLOW;
            end
            ST_WAITLOW: begin
                if (!req.psel) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bookkeeping lands as DONE is entered, so it is visible alongside req_pready.
        if (err_clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else if (done_err) begin
            err_cnt_d    = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
            err_sticky_d = 1'b1;
        end
        if (done_err) last_err_d = addr_d;
    end

    assign apb_sel   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign m.psel    = apb_sel;
    assign m.penable = (state_q == ST_ACCESS);
    assign m.pwrite  = apb_sel & write_q;
    assign m.paddr   = apb_sel ? addr_q : '0;
    assign m.pwdata  = apb_sel ? wdata_q : '0;

    assign req.pready = (state_q == ST_DONE);
    assign req.prdata = rdata_q;

    assign err_cnt       = err_cnt_q;
    assign err_sticky    = err_sticky_q;
    assign last_err_addr = last_err_q;

endmodule

// File: tb/tb_mdio_apb_bridge.sv
// Directed bench for mdio_apb_bridge: a cycle-window model predicts APB/completion
// activity per request and a negedge process compares the DUT against it every cycle.

module tb_mdio_apb_bridge;

    localparam int              AW    = 21;
    localparam logic [AW-1:0]   LIMIT = 21'h0FFFF;
    localparam int              TMO   = 255;
    localparam int              NCYC  = 16384;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    err_cnt;
    logic          err_sticky;
    logic [AW-1:0] last_err_addr;

    mdio_req_if        #(.ADDR_W(AW)) req_bus ();
    mdio_apb_bridge_if #(.ADDR_W(AW)) apb_bus ();

    mdio_apb_bridge #(
        .ADDR_W      (AW),
        .ADDR_LIMIT  (LIMIT),
        .TIMEOUT_CYC (TMO),
        .ERR_RDATA   (16'hFFFF)
    ) dut (
        .clk_200m      (clk),
        .rstn_200m     (rstn),
        .req           (req_bus),
        .m             (apb_bus),
        .err_clr       (err_clr),
        .err_cnt       (err_cnt),
        .err_sticky    (err_sticky),
        .last_err_addr (last_err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: expected per-cycle activity windows plus architectural error state.
    bit            e_psel [NCYC];
    bit            e_pen  [NCYC];
    bit            e_rdy  [NCYC];
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_wd;
    logic [15:0]   mdl_prdata = '0;
    int            mdl_cnt = 0;
    logic          mdl_sticky = 1'b0;
    logic [AW-1:0] mdl_last = '0;

    task automatic schedule(input int k, input logic wr, input logic [AW-1:0] a,
                            input logic [15:0] wd, input int w, input logic [15:0] rd,
                            input logic serr, output int done, output bit err);
        int acc;
        bit tmo;
        e_wr = wr; e_addr = a; e_wd = wd;
        if (a > LIMIT) begin
            done = k + 1;
            err  = 1'b1;
        end else begin
            tmo = (w < 0) || (w + 1 > TMO);
            acc = tmo ? TMO : w + 1;
            for (int c = k + 1; c <= k + 1 + acc; c++) if (c < NCYC) e_psel[c] = 1'b1;
            for (int c = k + 2; c <= k + 1 + acc; c++) if (c < NCYC) e_pen[c] = 1'b1;
            done = k + 2 + acc;
            err  = tmo || serr;
        end
        if (done < NCYC) e_rdy[done] = 1'b1;
        if (!wr) mdl_prdata = err ? 16'hFFFF : rd;
    endtask

    task automatic model_reset(input int from);
        for (int c = from; c < NCYC; c++) begin
            e_psel[c] = 1'b0; e_pen[c] = 1'b0; e_rdy[c] = 1'b0;
        end
        mdl_cnt = 0; mdl_sticky = 1'b0; mdl_last = '0; mdl_prdata = '0;
    endtask

    // APB responder: pready in ACCESS cycle cur_wait+1; cur_wait<0 means never.
    int cur_wait = -1;
    int acc_n = 0;
    always @(negedge clk) begin
        if (apb_bus.psel && apb_bus.penable) begin
            acc_n = acc_n + 1;
            apb_bus.pready = (cur_wait >= 0) && (acc_n == cur_wait + 1);
        end else begin
            acc_n = 0;
            apb_bus.pready = 1'b0;
        end
    end

    bit   chk_en = 1'b0;
    int   psel_rises = 0;
    int   rdy_pulses = 0;
    logic psel_prev = 1'b0;

    always @(negedge clk) begin
        if (rstn && chk_en && cyc < NCYC) begin
            chk("m_psel", apb_bus.psel, e_psel[cyc]);
            chk("m_penable", apb_bus.penable, e_pen[cyc]);
            chk("req_pready", req_bus.pready, e_rdy[cyc]);
            if (e_psel[cyc]) begin
                chk("m_paddr", apb_bus.paddr, e_addr);
                chk("m_pwrite", apb_bus.pwrite, e_wr);
                chk("m_pwdata", apb_bus.pwdata, e_wd);
            end
            if (e_rdy[cyc]) chk("req_prdata", req_bus.prdata, mdl_prdata);
            if (apb_bus.psel && !psel_prev) psel_rises++;
            if (req_bus.pready) rdy_pulses++;
        end
        psel_prev <= apb_bus.psel;
    end

    task automatic check_stats(input string tag);
        chk({tag, "_err_cnt"}, err_cnt, mdl_cnt);
        chk({tag, "_err_sticky"}, err_sticky, mdl_sticky);
        chk({tag, "_last_err_addr"}, last_err_addr, mdl_last);
        chk({tag, "_req_prdata"}, req_bus.prdata, mdl_prdata);
    endtask

    int txn_no = 0;

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [15:0] wd,
                          input int w, input logic [15:0] rd, input logic serr,
                          input bit clr, input int hold, output int lat);
        int  k, done;
        bit  err, seen;
        @(posedge clk); #1;
        k = cyc;
        req_bus.pwrite = wr; req_bus.paddr = a; req_bus.pwdata = wd; req_bus.psel = 1'b1;
        cur_wait = w; apb_bus.prdata = rd; apb_bus.pslverr = serr;
        schedule(k, wr, a, wd, w, rd, serr, done, err);
        seen = 1'b0;
        lat  = -1;
        for (int n = 0; n < 400 && !seen; n++) begin
            err_clr = clr && (cyc == done - 1);
            @(negedge clk);
            if (req_bus.pready) begin
                seen = 1'b1;
                lat  = cyc - k + 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        err_clr = 1'b0;
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL req_wait: no req_pready within 400 cycles for addr %0h", a);
        end
        if (err) begin
            if (clr) begin mdl_cnt = 0; mdl_sticky = 1'b0; end
            else begin if (mdl_cnt < 255) mdl_cnt++; mdl_sticky = 1'b1; end
            mdl_last = a;
        end else if (clr) begin
            mdl_cnt = 0; mdl_sticky = 1'b0;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        req_bus.psel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        txn_no++;
        $display("txn %0d: %s addr=%06h wdata=%04h wait=%0d slverr=%0d -> latency=%0d prdata=%04h err_cnt=%0d",
                 txn_no, wr ? "WR" : "RD", a, wd, w, serr, lat, req_bus.prdata, err_cnt);
        check_stats("txn");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, p0, k, dn;
        bit er;
        req_bus.psel = 1'b0; req_bus.pwrite = 1'b0; req_bus.paddr = '0; req_bus.pwdata = '0;
        apb_bus.prdata = '0; apb_bus.pslverr = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_psel", apb_bus.psel, 0);
        chk("rst_m_penable", apb_bus.penable, 0);
        chk("rst_req_pready", req_bus.pready, 0);
        chk("rst_req_prdata", req_bus.prdata, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_last_err_addr", last_err_addr, 0);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Zero-wait read.
        r0 = rdy_pulses;
        do_req(1'b0, 21'h00010, 16'h0000, 0, 16'hA5A5, 1'b0, 1'b0, 0, lat);
        chk("rd0_latency", lat, 4);
        chk("rd0_prdata", req_bus.prdata, 16'hA5A5);
        chk("rd0_err_cnt", err_cnt, 0);

        // Write with 3 wait states: read data must be untouched.
        r0 = rdy_pulses;
        do_req(1'b1, 21'h00020, 16'h1234, 3, 16'h0BAD, 1'b0, 1'b0, 0, lat);
        chk("wr3_latency", lat, 7);
        chk("wr3_pulses", rdy_pulses - r0, 1);
        chk("wr3_prdata_kept", req_bus.prdata, 16'hA5A5);

        // Slave never answers.
        do_req(1'b0, 21'h00030, 16'h0000, -1, 16'h1111, 1'b0, 1'b0, 0, lat);
        chk("tmo_latency", lat, 258);
        chk("tmo_prdata", req_bus.prdata, 16'hFFFF);
        chk("tmo_err_cnt", err_cnt, 1);
        chk("tmo_last_addr", last_err_addr, 21'h00030);

        // Above the address limit: no APB activity at all.
        p0 = psel_rises;
        do_req(1'b0, 21'h10000, 16'h0000, 0, 16'h2222, 1'b0, 1'b0, 0, lat);
        chk("lim_latency", lat, 2);
        chk("lim_no_psel", psel_rises - p0, 0);
        chk("lim_prdata", req_bus.prdata, 16'hFFFF);
        chk("lim_sticky", err_sticky, 1);
        chk("lim_err_cnt", err_cnt, 2);

        // Exactly at the limit is legal.
        do_req(1'b0, 21'h0FFFF, 16'h0000, 1, 16'h5A5A, 1'b0, 1'b0, 0, lat);
        chk("edge_latency", lat, 5);
        chk("edge_prdata", req_bus.prdata, 16'h5A5A);
        chk("edge_err_cnt", err_cnt, 2);

        // Slave error on a read.
        do_req(1'b0, 21'h00040, 16'h0000, 2, 16'h7777, 1'b1, 1'b0, 0, lat);
        chk("serr_prdata", req_bus.prdata, 16'hFFFF);
        chk("serr_err_cnt", err_cnt, 3);

        // Plain clear.
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        mdl_cnt = 0; mdl_sticky = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_sticky", err_sticky, 0);

        // Saturation.
        for (int i = 0; i < 256; i++)
            do_req(1'b1, 21'h00100 + AW'(i), 16'(i), 0, 16'h0000, 1'b1, 1'b0, 0, lat);
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_last_addr", last_err_addr, 21'h001FF);

        // Clear coincident with an error wins.
        do_req(1'b1, 21'h00050, 16'hBEEF, 1, 16'h0000, 1'b1, 1'b1, 0, lat);
        chk("coinc_err_cnt", err_cnt, 0);
        chk("coinc_sticky", err_sticky, 0);

        // Request held 10 cycles past completion issues one transfer.
        p0 = psel_rises; r0 = rdy_pulses;
        do_req(1'b0, 21'h00060, 16'h0000, 0, 16'hC3C3, 1'b0, 1'b0, 10, lat);
        chk("hold_psel_rises", psel_rises - p0, 1);
        chk("hold_pready_pulses", rdy_pulses - r0, 1);
        chk("hold_prdata", req_bus.prdata, 16'hC3C3);

        // Async reset during ACCESS.
        @(posedge clk); #1;
        k = cyc;
        req_bus.pwrite = 1'b0; req_bus.paddr = 21'h00070; req_bus.pwdata = '0; req_bus.psel = 1'b1;
        cur_wait = -1;
        schedule(k, 1'b0, 21'h00070, 16'h0000, -1, 16'h0000, 1'b0, dn, er);
        repeat (4) @(posedge clk);
        #2;
        chk("prerst_penable", apb_bus.penable, 1);
        rstn = 1'b0;
        model_reset(cyc);
        #1;
        chk("arst_m_psel", apb_bus.psel, 0);
        chk("arst_m_penable", apb_bus.penable, 0);
        chk("arst_req_pready", req_bus.pready, 0);
        chk("arst_req_prdata", req_bus.prdata, 0);
        chk("arst_last_err_addr", last_err_addr, 0);
        req_bus.psel = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);

        do_req(1'b0, 21'h00080, 16'h0000, 0, 16'h2468, 1'b0, 1'b0, 0, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_prdata", req_bus.prdata, 16'h2468);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
